dmem_ctrl: RTL

Data-memory access controller between the pipeline's load/store stage and the single-port-per-direction data RAM. Accepts one load or store request per cycle over a valid/ready handshake, posts stores into a small in-order write buffer that drains to RAM in idle slots, and serves loads either by store-to-load forwarding from the buffer or by a RAM read. It guarantees the RAM never sees read and write strobes in the same cycle, because the RAM drops the write when both are asserted.

---
 rtl/dmem_ctrl_if.sv | 36 +++
 rtl/dmem_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Bundle between the load/store stage, the data-memory controller and the data RAM.
// Request side: req_valid/req_ready/req_we/req_addr/req_wdata.
// Response side: rsp_valid/rsp_rdata, plus the wbuf_empty fence indication.
// RAM side: mem_rd/mem_raddr, mem_wr/mem_waddr/mem_wdata, and mem_rdata returned one cycle after mem_rd.
// master: the pipeline and RAM environment. slave: dmem_ctrl.
interface dmem_ctrl_if #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              wbuf_empty;
  logic              mem_rd;
  logic [AWIDTH-1:0] mem_raddr;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, wbuf_empty,
           mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, wbuf_empty,
           mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller. It takes one load or store per cycle.
// - Stores are posted into an in-order write buffer that drains to RAM in idle slots.
// - Loads are served by forwarding from the buffer, or otherwise by a RAM read.
// - The RAM never sees mem_rd and mem_wr together.
// Ports:
//   clk, rst - clock and asynchronous active-low reset.
//   bus      - dmem_ctrl_if.slave. Inputs: req_*, mem_rdata.
//              Registered outputs: rsp_*, mem_*, wbuf_empty.
//              req_ready is combinational on req_we and the buffer/FSM state.
module dmem_ctrl #(
  parameter int unsigned AWIDTH     = 8,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } wbuf_entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  wbuf_entry_t       r_buf [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  w_idx;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_full;
  logic              w_req_ready;
  logic              w_push;
  logic              w_load;
  logic              w_miss;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DWIDTH-1:0] w_fwd_data;

  logic              r_mem_rd;
  logic [AWIDTH-1:0] r_mem_raddr;
  logic              r_mem_wr;
  logic [AWIDTH-1:0] r_mem_waddr;
  logic [DWIDTH-1:0] r_mem_wdata;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_wbuf_empty;

  // Store-to-load forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = r_head;
    for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_buf[w_idx].addr == bus.req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_buf[w_idx].data;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_full      = (r_count == CNT_W'(WBUF_DEPTH));
    w_req_ready = bus.req_we ? !w_full : (r_state == IDLE);
    w_push      = bus.req_valid && w_req_ready && bus.req_we;
    w_load      = bus.req_valid && w_req_ready && !bus.req_we;
    w_miss      = w_load && !w_fwd_hit;

    case (r_state)
      IDLE:     if (w_miss) w_state_nxt = RD_ISSUE;
      RD_ISSUE: w_state_nxt = RD_WAIT;
      RD_WAIT:  w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase

    // The read slot has priority: no pop when the next cycle issues a RAM read.
    w_pop       = (r_count != '0) && (w_state_nxt != RD_ISSUE);
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Buffer pointers, RAM strobes and the response register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_raddr  <= '0;
      r_mem_wr     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_wbuf_empty <= 1'b1;
    end else begin
      r_head       <= r_head + PTR_W'(w_pop);
      r_tail       <= r_tail + PTR_W'(w_push);
      r_count      <= w_count_nxt;
      r_mem_rd     <= (w_state_nxt == RD_ISSUE);
      if (w_miss) r_mem_raddr <= bus.req_addr;
      r_mem_wr     <= w_pop;
      if (w_pop) begin
        r_mem_waddr <= r_buf[r_head].addr;
        r_mem_wdata <= r_buf[r_head].data;
      end
      // The RAM data is valid during RD_WAIT, so it is captured on the way back to IDLE.
      r_rsp_valid  <= (w_load && w_fwd_hit) || (r_state == RD_WAIT);
      if (w_load && w_fwd_hit)    r_rsp_rdata <= w_fwd_data;
      else if (r_state == RD_WAIT) r_rsp_rdata <= bus.mem_rdata;
      // Empty only when nothing is buffered and no write is about to be presented.
      r_wbuf_empty <= (w_count_nxt == '0) && !w_pop;
    end
  end

  // Buffer storage needs no reset; validity comes from the pointers and the count.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_tail] <= '{addr: bus.req_addr, data: bus.req_wdata};
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.wbuf_empty = r_wbuf_empty;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_raddr  = r_mem_raddr;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_waddr  = r_mem_waddr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule
